// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity modes and parity helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;
  localparam int MAX_BITS    = 9;
  function automatic logic parity_of(input logic [MAX_BITS-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter pulsing tick_o on its terminal count
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = $clog2(CLKS_PER_BIT);
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_baud_tick: CLKS_PER_BIT must be >= 2");
  end
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == W'(CLKS_PER_BIT - 1);
  assign cnt_d  = (clr_i || tick_o) ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk) begin
    cnt_q <= rst ? '0 : cnt_d;
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready word in, start/data/parity/stop serial frame out
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy
);
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_q, bit_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d, ready_q, busy_q;
  logic                 tick, accept, last_data, last_stop, idle;
  assign idle      = state_q == IDLE;
  assign accept    = in_valid & ready_q & idle;
  assign last_data = bit_q == 4'(DATA_BITS - 1);
  assign last_stop = bit_q == 4'(STOP_BITS - 1);
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (idle),
    .tick_o (tick)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = START;
        shift_d = in_data;
        bit_d   = '0;
        par_d   = parity_of(MAX_BITS'(in_data)) ^ (PARITY == PARITY_ODD);
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = last_data ? '0 : bit_q + 4'd1;
        state_d = !last_data ? DATA : (PARITY != PARITY_NONE) ? PAR : STOP;
      end
      PAR: if (tick) state_d = STOP;
      STOP: if (tick) begin
        bit_d   = last_stop ? '0 : bit_q + 4'd1;
        state_d = last_stop ? IDLE : STOP;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs follow the next state so tx, in_ready and busy switch on one edge
  assign tx_d = (state_d == START) ? 1'b0 :
                (state_d == DATA)  ? shift_d[0] :
                (state_d == PAR)   ? par_d : 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= state_d == IDLE;
      busy_q  <= state_d != IDLE;
    end
  end
  assign in_ready = ready_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three parity/stop variants driven together, checked against a frame-level model
module tb_uart_tx;
  localparam int CPB = 4;
  localparam int NI  = 3;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [NI-1:0] tx, rdy, bsy;
  int pc[NI] = '{0, 1, 2};
  int sc[NI] = '{1, 1, 2};
  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .tx(tx[0]), .busy(bsy[0]));
  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .tx(tx[1]), .busy(bsy[1]));
  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[2]), .tx(tx[2]), .busy(bsy[2]));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  int acc0[$];
  int k[NI] = '{-1, -1, -1};
  logic [11:0] fb[NI];
  logic e_tx[NI]  = '{1'b1, 1'b1, 1'b1};
  logic e_rdy[NI] = '{1'b0, 1'b0, 1'b0};
  logic e_bsy[NI] = '{1'b0, 1'b0, 1'b0};
  function automatic int flen(input int p, input int s);
    return (1 + 8 + (p != 0 ? 1 : 0) + s) * CPB;
  endfunction
  function automatic logic [11:0] frame(input logic [7:0] w, input int p);
    logic [11:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = w;
    if (p != 0) f[9] = (^w) ^ (p == 2);
    return f;
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", n, cyc, got, exp);
    end
  endtask
  always @(posedge clk) begin : model
    for (int i = 0; i < NI; i++) begin
      int kk;
      logic r;
      logic [11:0] fbn;
      kk = k[i];
      r = e_rdy[i];
      fbn = fb[i];
      if (rst) begin
        kk = -1;
        r = 1'b0;
      end else if (kk >= 0) begin
        kk++;
        if (kk == flen(pc[i], sc[i])) begin
          kk = -1;
          r = 1'b1;
        end
      end else if (in_valid && r) begin
        kk = 0;
        r = 1'b0;
        fbn = frame(in_data, pc[i]);
        if (i == 0) acc0.push_back(cyc);
      end else r = 1'b1;
      k[i] <= kk;
      fb[i] <= fbn;
      e_rdy[i] <= r;
      e_bsy[i] <= kk >= 0;
      e_tx[i] <= kk >= 0 ? fbn[kk / CPB] : 1'b1;
    end
    cyc <= cyc + 1;
  end
  always @(negedge clk) begin : compare
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("tx%0d", i), 32'(tx[i]), 32'(e_tx[i]));
      chk($sformatf("in_ready%0d", i), 32'(rdy[i]), 32'(e_rdy[i]));
      chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(e_bsy[i]));
    end
  end
  task automatic wait_acc(input int target);
    for (int n = 0; n < 200 && acc0.size() < target; n++) @(negedge clk);
    if (acc0.size() < target) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout cycle %0d: got %0d accepts expected %0d", cyc, acc0.size(), target);
    end
  endtask
  task automatic send(input logic [7:0] w);
    in_data = w;
    in_valid = 1'b1;
    wait_acc(acc0.size() + 1);
    in_valid = 1'b0;
  endtask
  initial begin
    logic [11:0] f;
    logic [9:0] pat;
    int n0;
    f = frame(8'hA5, 0);
    chk("model_frame_a5", 32'(f), 32'hF4A);
    f = frame(8'h07, 1);
    chk("model_even_07", 32'(f[9]), 32'd1);
    f = frame(8'h07, 2);
    chk("model_odd_07", 32'(f[9]), 32'd0);
    chk("model_flen_p0", flen(0, 1), 32'd40);
    chk("model_flen_p1", flen(1, 1), 32'd44);
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx[0]), 32'd1);
    chk("rst_ready", 32'(rdy[0]), 32'd0);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(rdy[0]), 32'd1);
    pat = 10'b1101001010;
    send(8'hA5);
    for (int n = 0; n < 41; n++) begin
      if (n % 4 == 2) chk($sformatf("a5_bit%0d", n / 4), 32'(tx[0]), 32'(pat[n / 4]));
      if (n == 39) chk("a5_ready_end", 32'(rdy[0]), 32'd0);
      if (n == 40) begin
        chk("a5_ready_41", 32'(rdy[0]), 32'd1);
        chk("a5_busy_41", 32'(bsy[0]), 32'd0);
      end
      @(negedge clk);
    end
    repeat (60) @(negedge clk);
    send(8'h07);
    for (int n = 0; n < 45; n++) begin
      if (n == 38) begin
        chk("even_par_07", 32'(tx[1]), 32'd1);
        chk("odd_par_07", 32'(tx[2]), 32'd0);
      end
      if (n == 43) chk("p1_busy_43", 32'(bsy[1]), 32'd1);
      if (n == 44) chk("p1_busy_44", 32'(bsy[1]), 32'd0);
      @(negedge clk);
    end
    repeat (60) @(negedge clk);
    n0 = acc0.size();
    in_data = 8'h11;
    in_valid = 1'b1;
    wait_acc(n0 + 1);
    in_data = 8'h22;
    wait_acc(n0 + 2);
    in_valid = 1'b0;
    if (acc0.size() >= n0 + 2) chk("b2b_spacing", 32'(acc0[n0 + 1] - acc0[n0]), 32'd41);
    repeat (60) @(negedge clk);
    send(8'hA5);
    repeat (10) @(negedge clk);
    n0 = acc0.size();
    in_data = 8'hFF;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("no_midframe_accept", 32'(acc0.size()), 32'(n0));
    repeat (60) @(negedge clk);
    send(8'hA5);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx", 32'(tx[0]), 32'd1);
    chk("abort_busy", 32'(bsy[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send(8'h3C);
    repeat (60) @(negedge clk);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = $urandom_range(0, 299) == 0;
      in_valid = $urandom_range(0, 2) != 0;
      in_data = 8'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (60) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
